rv_core_fde: RTL and testbench
==============================

// Module: rv_core_fde
// PURPOSE
// - Three-stage in-order RV32I integer pipeline: fetch -> decode (register file read) -> execute (ALU and writeback).
// - Wraps the fetch, decode and execute stage modules and exposes an instruction-memory request port.
// - Exposes a retire/observation port carrying each executed result.
// - Covers the integer ALU subset only: OP-IMM, OP, LUI, AUIPC. No loads, stores or branch resolution.
// PARAMETERS
// - XLEN      32   datapath and register width (only 32 is supported)
// - RESET_PC  0    fetch address after reset
// PORTS
// - req                     in   1   clock, rising edge
// - reset                   in   1   asynchronous, active-high reset
// - instr_req_out           out  1   instruction fetch request
// - instr_addr_out          out  32  fetch address (current PC)
// - gnt_in                  in   1   memory accepted the request
// - instr_rvalid_in         in   1   instr_rdata_in is valid this cycle
// - instr_rdata_in          in   32  fetched instruction word
// - branch_mispredicted_in  in   1   flush fetch/decode and redirect
// - branch_target_in        in   32  redirect PC used with branch_mispredicted_in
// - result_out              out  32  result of the last executed instruction
// - rd_out                  out  5   destination register of result_out
// - rd_write_out            out  1   result_out was written to the register file
// - alu_non_zero_out        out  1   result_out != 0
// - pc_out                  out  32  PC of the instruction that produced result_out
// BEHAVIOUR
// - Reset (async, active-high):
//   - PC = RESET_PC; all stage valid bits = 0; x0..x31 = 0.
//   - result_out = 0, rd_out = 0, rd_write_out = 0, alu_non_zero_out = 0, pc_out = 0.
//   - instr_req_out = 0 while reset is asserted, 1 otherwise. instr_addr_out = PC.
// - Fetch:
//   - At a req edge with gnt_in && instr_rvalid_in, capture instruction and PC, set fetch valid, PC += 4.
//   - Otherwise hold PC and insert a bubble.
// - Decode:
//   - One cycle after fetch. Extracts rd/rs1/rs2/funct3/funct7 and the I/U immediate.
//   - Reads rs1 and rs2 from the 32x32 register file; x0 always reads 0.
//   - Forwarding: if execute writes a register in the same cycle decode reads it, decode takes the execute result.
//   - Opcodes other than 0010011, 0110011, 0110111, 0010111, or any X/Z bits, produce a bubble (valid = 0). A bubble is never an error.
// - Execute:
//   - Combinational ALU on the decode register outputs.
//     - ADD/SUB: SUB when OP and funct7[5] = 1.
//     - SLL, SLT, SLTU, XOR, OR, AND.
//     - SRL/SRA: SRA when funct7[5] = 1. Shift amount is operand2[4:0].
//     - LUI = imm; AUIPC = pc + imm.
//   - Arithmetic is modulo 2^32. SLT is signed, SLTU is unsigned.
//   - At the req edge, if valid: write rd (skipped when rd = 0) and update all observation outputs.
//     rd_write_out = (rd != 0).
//   - A bubble sets rd_write_out = 0 and leaves the other observation outputs unchanged.
// - Latency: an instruction accepted at edge N updates result_out at edge N+2 and is readable by an instruction decoded at edge N+2 or later.
//   Back-to-back dependent instructions execute without stalls.
// - branch_mispredicted_in sampled high:
//   - PC = branch_target_in.
//   - Fetch and decode valid are cleared, killing the two younger instructions.
//   - The instruction in execute completes.
//   - Mispredict takes priority over a simultaneous fetch.
// - Reset asserted mid-operation: all in-flight instructions are discarded immediately.
// STRUCTURE
// - Package rv_pkg: opcode constants (OP_IMM, OP, LUI, AUIPC), funct3 encodings, ALU-op enum, XLEN.
// - Stage modules fetch, decode and execute are connected by rv_core_fde.
// - One sub-module, rv_regfile: 2 read ports, 1 write port, x0 hardwired to 0.
//   Instantiated in decode, write port driven by execute.
// TESTING
// - Reset, then addi x1,x1,1 (0x00108093)
//   -> result_out = 1, rd_out = 1, rd_write_out = 1 two edges later.
// - Stream addi x1,x1,1; addi x3,x3,3; addi x4,x4,4; add x2,x1,x1, one per cycle
//   -> results 1, 3, 4, 2; x1 = 1, x2 = 2, x3 = 3, x4 = 4.
// - addi x5,x0,-1 then sltu x6,x0,x5 and slt x7,x0,x5 back to back
//   -> x6 = 1 (forwarding exercised), x7 = 0.
// - addi x0,x0,5 -> rd_write_out = 0, x0 reads 0; all-X or unsupported word -> bubble, no register change.
// - branch_mispredicted_in with branch_target_in = 0x100
//   -> instr_addr_out = 0x100 next cycle; the two younger instructions never update result_out.
// - gnt_in = 0 for 3 cycles -> PC held, no writes; reset asserted mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the rv_core_fde integer pipeline: opcodes, funct3
// encodings, the ALU operation set and its decode helper.
package rv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_t;

   // alt is instruction bit 30; it selects SUB only for register-register ops.
   function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt,
                                          input logic reg_op);
      case (funct3)
         F3_ADD:  return (alt && reg_op) ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/rv_decode.sv
// Decode stage: field extraction, register read with execute forwarding,
// operand selection and the decode pipeline register.
module rv_decode import rv_pkg::*; (
   input  logic            req,
   input  logic            reset,
   input  logic            flush,
   input  logic            f_valid,
   input  logic [XLEN-1:0] f_instr,
   input  logic [XLEN-1:0] f_pc,
   input  logic            wr_en,
   input  logic [4:0]      wr_addr,
   input  logic [XLEN-1:0] wr_data,
   output logic            d_valid,
   output alu_op_t         d_alu_op,
   output logic [XLEN-1:0] d_op_a,
   output logic [XLEN-1:0] d_op_b,
   output logic [4:0]      d_rd,
   output logic [XLEN-1:0] d_pc
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rs1, rs2;
   logic [XLEN-1:0] rf_rs1, rf_rs2, rs1_val, rs2_val, imm_i, imm_u, op_a, op_b;
   logic            legal;
   alu_op_t         alu_op;

   assign opcode = f_instr[6:0];
   assign funct3 = f_instr[14:12];
   assign rs1    = f_instr[19:15];
   assign rs2    = f_instr[24:20];
   assign imm_i  = {{20{f_instr[31]}}, f_instr[31:20]};
   assign imm_u  = {f_instr[31:12], 12'h000};

   rv_regfile u_regfile (
      .req   (req),
      .reset (reset),
      .ra1   (rs1),
      .ra2   (rs2),
      .rd1   (rf_rs1),
      .rd2   (rf_rs2),
      .we    (wr_en),
      .wa    (wr_addr),
      .wd    (wr_data)
   );

   // Execute writes at the same edge this stage latches, so bypass the file.
   assign rs1_val = (wr_en && wr_addr == rs1) ? wr_data : rf_rs1;
   assign rs2_val = (wr_en && wr_addr == rs2) ? wr_data : rf_rs2;

   always_comb begin
      legal  = 1'b0;
      alu_op = ALU_ADD;
      op_a   = rs1_val;
      op_b   = rs2_val;
      case (opcode)
         OP_IMM: begin
            legal  = 1'b1;
            op_b   = imm_i;
            alu_op = alu_decode(funct3, f_instr[30], 1'b0);
         end
         OP: begin
            legal  = 1'b1;
            alu_op = alu_decode(funct3, f_instr[30], 1'b1);
         end
         LUI: begin
            legal = 1'b1;
            op_a  = '0;
            op_b  = imm_u;
         end
         AUIPC: begin
            legal = 1'b1;
            op_a  = f_pc;
            op_b  = imm_u;
         end
         default: ;
      endcase
   end

   always_ff @(posedge req or posedge reset) begin
      if (reset) begin
         d_valid  <= 1'b0;
         d_alu_op <= ALU_ADD;
         d_op_a   <= '0;
         d_op_b   <= '0;
         d_rd     <= '0;
         d_pc     <= '0;
      end else begin
         d_valid  <= f_valid && legal && !flush;
         d_alu_op <= alu_op;
         d_op_a   <= op_a;
         d_op_b   <= op_b;
         d_rd     <= f_instr[11:7];
         d_pc     <= f_pc;
      end
   end

endmodule

// File: rtl/rv_execute.sv
// Execute stage: ALU, register writeback request and the retire/observation
// registers.
module rv_execute import rv_pkg::*; (
   input  logic            req,
   input  logic            reset,
   input  logic            d_valid,
   input  alu_op_t         d_alu_op,
   input  logic [XLEN-1:0] d_op_a,
   input  logic [XLEN-1:0] d_op_b,
   input  logic [4:0]      d_rd,
   input  logic [XLEN-1:0] d_pc,
   output logic            wr_en,
   output logic [4:0]      wr_addr,
   output logic [XLEN-1:0] wr_data,
   output logic [XLEN-1:0] result_out,
   output logic [4:0]      rd_out,
   output logic            rd_write_out,
   output logic            alu_non_zero_out,
   output logic [XLEN-1:0] pc_out
);

   logic [XLEN-1:0] alu;
   logic [4:0]      shamt;

   assign shamt = d_op_b[4:0];

   always_comb begin
      alu = '0;
      case (d_alu_op)
         ALU_ADD:  alu = d_op_a + d_op_b;
         ALU_SUB:  alu = d_op_a - d_op_b;
         ALU_SLL:  alu = d_op_a << shamt;
         ALU_SLT:  alu = {31'b0, $signed(d_op_a) < $signed(d_op_b)};
         ALU_SLTU: alu = {31'b0, d_op_a < d_op_b};
         ALU_XOR:  alu = d_op_a ^ d_op_b;
         ALU_SRL:  alu = d_op_a >> shamt;
         ALU_SRA:  alu = $signed(d_op_a) >>> shamt;
         ALU_OR:   alu = d_op_a | d_op_b;
         ALU_AND:  alu = d_op_a & d_op_b;
         default:  alu = '0;
      endcase
   end

   assign wr_en   = d_valid && d_rd != '0;
   assign wr_addr = d_rd;
   assign wr_data = alu;

   always_ff @(posedge req or posedge reset) begin
      if (reset) begin
         result_out       <= '0;
         rd_out           <= '0;
         rd_write_out     <= 1'b0;
         alu_non_zero_out <= 1'b0;
         pc_out           <= '0;
      end else if (d_valid) begin
         result_out       <= alu;
         rd_out           <= d_rd;
         rd_write_out     <= d_rd != '0;
         alu_non_zero_out <= alu != '0;
         pc_out           <= d_pc;
      end else begin
         rd_write_out     <= 1'b0;
      end
   end

endmodule

// File: rtl/rv_fetch.sv
// Fetch stage: owns the PC, captures granted/valid instruction words and
// applies mispredict redirects.
module rv_fetch import rv_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            req,
   input  logic            reset,
   output logic            instr_req_out,
   output logic [XLEN-1:0] instr_addr_out,
   input  logic            gnt_in,
   input  logic            instr_rvalid_in,
   input  logic [XLEN-1:0] instr_rdata_in,
   input  logic            branch_mispredicted_in,
   input  logic [XLEN-1:0] branch_target_in,
   output logic            f_valid,
   output logic [XLEN-1:0] f_instr,
   output logic [XLEN-1:0] f_pc
);

   logic [XLEN-1:0] pc;

   always_ff @(posedge req or posedge reset) begin
      if (reset) begin
         pc      <= RESET_PC;
         f_valid <= 1'b0;
         f_instr <= '0;
         f_pc    <= '0;
      end else if (branch_mispredicted_in) begin
         pc      <= branch_target_in;
         f_valid <= 1'b0;
      end else if (gnt_in && instr_rvalid_in) begin
         pc      <= pc + 32'd4;
         f_valid <= 1'b1;
         f_instr <= instr_rdata_in;
         f_pc    <= pc;
      end else begin
         f_valid <= 1'b0;
      end
   end

   assign instr_req_out  = !reset;
   assign instr_addr_out = pc;

endmodule

// File: rtl/rv_regfile.sv
// 32x32 integer register file: two combinational read ports, one write port,
// x0 hardwired to zero.
module rv_regfile import rv_pkg::*; (
   input  logic            req,
   input  logic            reset,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd
);

   logic [XLEN-1:0] regs [32];

   always_ff @(posedge req or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && wa != '0) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/rv_core_fde.sv
// Three-stage RV32I integer pipeline (fetch -> decode -> execute) covering
// OP-IMM, OP, LUI and AUIPC, with a retire observation port.
module rv_core_fde #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            req,
   input  logic            reset,
   output logic            instr_req_out,
   output logic [XLEN-1:0] instr_addr_out,
   input  logic            gnt_in,
   input  logic            instr_rvalid_in,
   input  logic [XLEN-1:0] instr_rdata_in,
   input  logic            branch_mispredicted_in,
   input  logic [XLEN-1:0] branch_target_in,
   output logic [XLEN-1:0] result_out,
   output logic [4:0]      rd_out,
   output logic            rd_write_out,
   output logic            alu_non_zero_out,
   output logic [XLEN-1:0] pc_out
);
   import rv_pkg::*;

   logic            f_valid, d_valid, wr_en;
   logic [XLEN-1:0] f_instr, f_pc, d_op_a, d_op_b, d_pc, wr_data;
   logic [4:0]      d_rd, wr_addr;
   alu_op_t         d_alu_op;

   rv_fetch #(.RESET_PC(RESET_PC)) u_fetch (
      .req                    (req),
      .reset                  (reset),
      .instr_req_out          (instr_req_out),
      .instr_addr_out         (instr_addr_out),
      .gnt_in                 (gnt_in),
      .instr_rvalid_in        (instr_rvalid_in),
      .instr_rdata_in         (instr_rdata_in),
      .branch_mispredicted_in (branch_mispredicted_in),
      .branch_target_in       (branch_target_in),
      .f_valid                (f_valid),
      .f_instr                (f_instr),
      .f_pc                   (f_pc)
   );

   rv_decode u_decode (
      .req      (req),
      .reset    (reset),
      .flush    (branch_mispredicted_in),
      .f_valid  (f_valid),
      .f_instr  (f_instr),
      .f_pc     (f_pc),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .d_valid  (d_valid),
      .d_alu_op (d_alu_op),
      .d_op_a   (d_op_a),
      .d_op_b   (d_op_b),
      .d_rd     (d_rd),
      .d_pc     (d_pc)
   );

   rv_execute u_execute (
      .req              (req),
      .reset            (reset),
      .d_valid          (d_valid),
      .d_alu_op         (d_alu_op),
      .d_op_a           (d_op_a),
      .d_op_b           (d_op_b),
      .d_rd             (d_rd),
      .d_pc             (d_pc),
      .wr_en            (wr_en),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .result_out       (result_out),
      .rd_out           (rd_out),
      .rd_write_out     (rd_write_out),
      .alu_non_zero_out (alu_non_zero_out),
      .pc_out           (pc_out)
   );

endmodule

// File: tb/tb_rv_core_fde.sv
// Self-checking bench for rv_core_fde: directed spec scenarios followed by
// randomized instruction streams against an in-order architectural model.
module tb_rv_core_fde;

   logic        req = 1'b0;
   logic        reset = 1'b1;
   logic        gnt_in = 1'b0;
   logic        instr_rvalid_in = 1'b0;
   logic [31:0] instr_rdata_in = '0;
   logic        branch_mispredicted_in = 1'b0;
   logic [31:0] branch_target_in = '0;
   logic        instr_req_out, rd_write_out, alu_non_zero_out;
   logic [31:0] instr_addr_out, result_out, pc_out;
   logic [4:0]  rd_out;

   int vectors = 0;
   int miscompares = 0;

   // Architectural model: register file, PC, two in-flight slots, expected outputs.
   logic [31:0] m_regs [32];
   logic [31:0] m_pc;
   bit          f_v, d_v;
   logic [31:0] f_w, f_p, d_w, d_p;
   logic [31:0] e_result, e_pc;
   logic [4:0]  e_rd;
   bit          e_wr, e_nz;

   always #5 req = ~req;

   rv_core_fde #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .req                    (req),
      .reset                  (reset),
      .instr_req_out          (instr_req_out),
      .instr_addr_out         (instr_addr_out),
      .gnt_in                 (gnt_in),
      .instr_rvalid_in        (instr_rvalid_in),
      .instr_rdata_in         (instr_rdata_in),
      .branch_mispredicted_in (branch_mispredicted_in),
      .branch_target_in       (branch_target_in),
      .result_out             (result_out),
      .rd_out                 (rd_out),
      .rd_write_out           (rd_write_out),
      .alu_non_zero_out       (alu_non_zero_out),
      .pc_out                 (pc_out)
   );

   function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                         logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] opc);
      return {imm, rd, opc};
   endfunction

   function automatic bit legal(logic [31:0] w);
      if ($isunknown(w)) return 1'b0;
      return w[6:0] == 7'h13 || w[6:0] == 7'h33 || w[6:0] == 7'h37 || w[6:0] == 7'h17;
   endfunction

   function automatic logic [31:0] ref_result(logic [31:0] w, logic [31:0] pc);
      logic [31:0] a, b, immi, immu;
      bit          reg_op;
      a      = m_regs[w[19:15]];
      immi   = {{20{w[31]}}, w[31:20]};
      immu   = {w[31:12], 12'h000};
      reg_op = (w[6:0] == 7'h33);
      if (w[6:0] == 7'h37) return immu;
      if (w[6:0] == 7'h17) return pc + immu;
      b = reg_op ? m_regs[w[24:20]] : immi;
      case (w[14:12])
         3'd0:    return (reg_op && w[30]) ? a - b : a + b;
         3'd1:    return a << b[4:0];
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return w[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pc = '0; f_v = 0; d_v = 0; f_w = '0; f_p = '0; d_w = '0; d_p = '0;
      e_result = '0; e_pc = '0; e_rd = '0; e_wr = 0; e_nz = 0;
   endtask

   task automatic model_edge(bit acc, logic [31:0] w, bit mp, logic [31:0] tgt);
      logic [31:0] r;
      logic [4:0]  rd;
      if (d_v && legal(d_w)) begin
         r  = ref_result(d_w, d_p);
         rd = d_w[11:7];
         if (rd != 0) m_regs[rd] = r;
         e_result = r; e_rd = rd; e_wr = (rd != 0); e_nz = (r != 0); e_pc = d_p;
      end else begin
         e_wr = 0;
      end
      if (mp) begin
         d_v = 0; f_v = 0; m_pc = tgt;
      end else begin
         d_v = f_v; d_w = f_w; d_p = f_p;
         f_v = acc; f_w = w; f_p = m_pc;
         if (acc) m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      cmp("result_out", result_out, e_result);
      cmp("rd_out", 32'(rd_out), 32'(e_rd));
      cmp("rd_write_out", 32'(rd_write_out), 32'(e_wr));
      cmp("alu_non_zero_out", 32'(alu_non_zero_out), 32'(e_nz));
      cmp("pc_out", pc_out, e_pc);
      cmp("instr_addr_out", instr_addr_out, m_pc);
      cmp("instr_req_out", 32'(instr_req_out), reset ? 32'd0 : 32'd1);
   endtask

   task automatic step(bit g, bit rv, logic [31:0] w, bit mp, logic [31:0] tgt);
      gnt_in = g; instr_rvalid_in = rv; instr_rdata_in = w;
      branch_mispredicted_in = mp; branch_target_in = tgt;
      @(posedge req);
      if (reset) model_reset();
      else model_edge(g && rv, w, mp, tgt);
      #1;
      check_all();
   endtask

   task automatic fetch(logic [31:0] w);
      step(1, 1, w, 0, '0);
   endtask

   task automatic idle();
      step(0, 0, '0, 0, '0);
   endtask

   // Asynchronous reset in mid-cycle; outputs must clear before any edge.
   task automatic do_reset();
      #2 reset = 1'b1;
      #1 model_reset();
      check_all();
      idle();
      reset = 1'b0;
   endtask

   function automatic logic [31:0] rand_word();
      logic [4:0] rd, rs1, rs2;
      logic [6:0] f7;
      int unsigned k;
      k   = $urandom_range(0, 9);
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      case (k)
         0, 1, 2, 3: return enc_i(12'($urandom), rs1, 3'($urandom), rd);
         4, 5, 6:    return enc_r(f7, rs2, rs1, 3'($urandom), rd);
         7:          return enc_u(20'($urandom), rd, 7'b0110111);
         8:          return enc_u(20'($urandom), rd, 7'b0010111);
         default:    return ($urandom_range(0, 1) == 1) ? 32'hxxxx_xxxx
                                                        : {25'($urandom), 7'b0000011};
      endcase
   endfunction

   initial begin
      model_reset();
      do_reset();

      // Single addi after reset.
      fetch(32'h0010_8093); idle(); idle();
      cmp("first_addi_result", result_out, 32'd1);
      cmp("first_addi_rd", 32'(rd_out), 32'd1);
      cmp("first_addi_write", 32'(rd_write_out), 32'd1);

      // Back-to-back stream with a dependent add, then read x1..x4 back.
      do_reset();
      fetch(32'h0010_8093);
      fetch(enc_i(12'd3, 5'd3, 3'd0, 5'd3));
      fetch(enc_i(12'd4, 5'd4, 3'd0, 5'd4));
      fetch(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2));
      idle(); idle();
      cmp("stream_add_x2", result_out, 32'd2);
      for (int r = 1; r <= 4; r++) fetch(enc_r(7'h00, 5'd0, 5'(r), 3'd0, 5'(r + 8)));
      idle(); idle();
      cmp("readback_x4", result_out, 32'd4);

      // Forwarded compare against -1.
      fetch(enc_i(12'hfff, 5'd0, 3'd0, 5'd5));
      fetch(enc_r(7'h00, 5'd5, 5'd0, 3'd3, 5'd6));
      fetch(enc_r(7'h00, 5'd5, 5'd0, 3'd2, 5'd7));
      idle(); idle();
      cmp("slt_x7", result_out, 32'd0);
      fetch(enc_r(7'h00, 5'd0, 5'd6, 3'd0, 5'd8));
      idle(); idle();
      cmp("sltu_x6", result_out, 32'd1);

      // x0 destination, then X and unsupported words.
      fetch(enc_i(12'd5, 5'd0, 3'd0, 5'd0)); idle(); idle();
      cmp("x0_no_write", 32'(rd_write_out), 32'd0);
      fetch(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd9)); idle(); idle();
      cmp("x0_reads_zero", result_out, 32'd0);
      fetch(32'hxxxx_xxxx); fetch(32'h0000_2083); idle(); idle();
      cmp("bubble_no_write", 32'(rd_write_out), 32'd0);

      // Mispredict kills the two younger instructions.
      fetch(enc_i(12'd7, 5'd0, 3'd0, 5'd10));
      fetch(enc_i(12'd8, 5'd0, 3'd0, 5'd11));
      step(1, 1, enc_i(12'd9, 5'd0, 3'd0, 5'd12), 1, 32'h100);
      cmp("mispredict_addr", instr_addr_out, 32'h100);
      idle(); idle();
      cmp("mispredict_kill", result_out, 32'd7);

      // No grant for three cycles.
      fetch(enc_i(12'd1, 5'd13, 3'd0, 5'd13));
      for (int i = 0; i < 3; i++) step(0, 1, enc_i(12'd2, 5'd0, 3'd0, 5'd14), 0, '0);
      cmp("gnt_low_pc_held", instr_addr_out, 32'h104);

      // Reset mid-stream.
      fetch(enc_i(12'd6, 5'd0, 3'd0, 5'd15));
      fetch(enc_i(12'd6, 5'd0, 3'd0, 5'd16));
      do_reset();
      cmp("midreset_result", result_out, 32'd0);
      cmp("midreset_addr", instr_addr_out, 32'd0);

      // Randomized streams with occasional stalls, redirects and a reset.
      for (int i = 0; i < 500; i++) begin
         if (i == 250) do_reset();
         if ($urandom_range(0, 99) < 3)
            step(1, 1, rand_word(), 1, {$urandom_range(0, 255), 2'b00});
         else
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, rand_word(), 0, '0);
      end
      idle(); idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
